conv_row_engine: RTL and testbench
==================================

Name: conv_row_engine

Overview:
- Parametrised K-tap 1-D convolution row: the next generation of the fixed 5-PE first-line convolution chain.
- Holds K signed weights in a register file loaded through a valid/ready handshake, and keeps a K-deep sliding window of streamed activations.
- Each complete window produces one partial sum: incoming psum plus the sum of the K products, saturated to O_SAT bits, with optional ReLU.
- Sits between the line buffer (activation/psum source) and the next convolution row or writeback.

Parameters:
K, 5, number of taps (window depth); legal range 2..16
I_X, 8, signed activation width
I_W, 8, signed weight width
I_PSUM, 16, signed incoming partial-sum width
O_SAT, 16, signed saturated output width
ACC_W (localparam), max(I_X+I_W+clog2(K), I_PSUM)+1, internal accumulator width; no overflow is possible before saturation

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_load  in  1  one-cycle pulse: start a weight load
i_w_valid  in  1  weight word valid
i_w  in  I_W  signed weight word
o_w_ready  out  1  high while weights are being accepted
i_x_valid  in  1  activation/psum sample valid
i_x  in  I_X  signed activation
i_psum  in  I_PSUM  signed partial sum, aligned with i_x
i_row_start  in  1  qualifies i_x_valid: this sample is the first of a new row
i_relu  in  1  output ReLU enable, sampled together with i_x
o_x_ready  out  1  high in RUN; samples are accepted only when this is high
o_psum  out  O_SAT  signed saturated result
o_valid  out  1  o_psum valid (one-cycle strobe per result)

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous and active-high (i_rst).
- Reset applies to all state, including mid-operation:
  - state goes to IDLE; weights, window, fill counter and pipeline valids are cleared to 0;
  - o_psum=0, o_valid=0, o_w_ready=0, o_x_ready=0.
- FSM states:
  - IDLE: no accepts.
  - LOAD: o_w_ready=1; weight index counter wcnt runs 0..K-1.
  - RUN: o_x_ready=1.
- Transitions:
  - i_load (any state, not in reset) -> LOAD. Clears wcnt, the fill counter and both pipeline valid bits. In-flight results are dropped.
  - LOAD: each cycle with i_w_valid=1 writes w[wcnt]=i_w and increments wcnt. The write with wcnt=K-1 goes to RUN at the same edge.
  - i_w_valid outside LOAD is ignored.
- Accepting a sample: i_x_valid && o_x_ready.
  - Window shifts: win[0]=i_x and win[k]=win[k-1], so win[k] is the sample accepted k samples earlier.
  - fill increments and saturates at K.
  - i_row_start=1 on an accepted sample sets fill=1 (the sample counts as the first of the row). The window contents are not cleared.
  - i_x_valid while o_x_ready=0 is ignored (no effect).
- Result condition: an accepted sample whose post-update fill==K produces exactly one result. Samples with fill<K produce nothing (warm-up of K-1 samples per row).
- Pipeline, with E the accepting edge:
  - E+1: the K products w[k]*win[k] (full I_X+I_W precision), i_psum (sign-extended) and i_relu are registered, with stage-1 valid.
  - E+2: o_psum and o_valid are updated. o_valid=1 for exactly one cycle per result.
  - Back-to-back accepts give back-to-back results. Fixed latency is 2; there is no backpressure.
- Arithmetic:
  - acc = sext(psum) + sum of sext(products), in ACC_W bits, signed.
  - Saturation: acc > 2^(O_SAT-1)-1 -> 2^(O_SAT-1)-1; acc < -2^(O_SAT-1) -> -2^(O_SAT-1); otherwise truncate to O_SAT bits.
  - ReLU, applied after saturation when the registered relu=1: a negative value becomes 0.
- When o_valid=0, o_psum holds its last value.
- Simultaneous i_load and accepted sample: i_load wins and the sample is discarded.
- i_row_start without i_x_valid has no effect.

Test Plan:
- Load, ramp input: w=[1,2,3,4,5] (w[0]..w[4]); i_x=1..7 with psum=0 and no gaps -> exactly 3 results, 35, 50, 65, each 2 cycles after the accepting edge of x=5, 6, 7; no o_valid during x=1..4.
- Psum add and ReLU: same weights; i_x=1..5 with the last psum=-35 -> result 0. Last psum=-40 with relu=0 -> result -5; with relu=1 -> result 0.
- Saturation: all w=127, all x=127, psum=32767 -> 32767. All w=-128, x=127, psum=-32768 -> -32768; the same case with relu=1 -> 0.
- Row restart and gaps: stream 7 samples, then i_row_start on the 8th -> no result for samples 8..11, next result at sample 12. Random i_x_valid gaps -> results unchanged; latency is counted from each accepting edge.
- Load handshake: i_w_valid held with gaps during LOAD -> only valid cycles are written; o_x_ready=0 until the K-th weight; i_x_valid in LOAD is ignored. i_load issued with 2 results in flight -> neither result appears.
- Reset mid-RUN: i_rst for 1 cycle with the pipeline full -> next cycle all outputs are 0 and the FSM is IDLE; samples are then ignored until a reload completes.

Source files
------------

// File: rtl/conv_row_engine.sv
// rtl/conv_row_engine.sv - parametrised K-tap 1-D convolution row with saturating psum output
module conv_row_engine #(
  parameter int K      = 5,
  parameter int I_X    = 8,
  parameter int I_W    = 8,
  parameter int I_PSUM = 16,
  parameter int O_SAT  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load,
  input  logic                     i_w_valid,
  input  logic signed [I_W-1:0]    i_w,
  output logic                     o_w_ready,
  input  logic                     i_x_valid,
  input  logic signed [I_X-1:0]    i_x,
  input  logic signed [I_PSUM-1:0] i_psum,
  input  logic                     i_row_start,
  input  logic                     i_relu,
  output logic                     o_x_ready,
  output logic signed [O_SAT-1:0]  o_psum,
  output logic                     o_valid
);

  localparam int P_W   = I_X + I_W;
  localparam int SUM_W = P_W + $clog2(K);
  localparam int ACC_W = ((SUM_W > I_PSUM) ? SUM_W : I_PSUM) + 1;
  localparam int WC_W  = $clog2(K);
  localparam int FC_W  = $clog2(K + 1);

  localparam logic [WC_W-1:0] W_LAST    = WC_W'(K - 1);
  localparam logic [FC_W-1:0] FILL_FULL = FC_W'(K);
  localparam logic [FC_W-1:0] FILL_ONE  = FC_W'(1);

  // Saturation bounds expressed in accumulator width (O_SAT never exceeds ACC_W here).
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-O_SAT+1){1'b0}}, {(O_SAT-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-O_SAT+1){1'b1}}, {(O_SAT-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                   state;
  logic [WC_W-1:0]          wcnt;
  logic signed [I_W-1:0]    w   [K];
  logic signed [I_X-1:0]    win [K];
  logic [FC_W-1:0]          fill;
  logic [FC_W-1:0]          fill_next;
  logic                     accept;

  // Window-stage sideband: result pending for the window just shifted in.
  logic                     x_hit;
  logic signed [I_PSUM-1:0] x_psum;
  logic                     x_relu;

  // Product stage.
  logic                     s1_valid;
  logic signed [P_W-1:0]    s1_prod [K];
  logic signed [I_PSUM-1:0] s1_psum;
  logic                     s1_relu;

  logic signed [ACC_W-1:0]  acc;
  logic signed [O_SAT-1:0]  sat_val;
  logic signed [O_SAT-1:0]  res_val;

  // A load request pre-empts any sample offered in the same cycle.
  assign accept = i_x_valid && o_x_ready && !i_load;

  // Row start restarts the warm-up count; otherwise count up and stick at K.
  always_comb begin
    fill_next = fill;
    if (i_row_start)
      fill_next = FILL_ONE;
    else if (fill != FILL_FULL)
      fill_next = fill + FILL_ONE;
  end

  // Control FSM: weight loading handshake and run-mode ready, outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      o_w_ready <= 1'b0;
      o_x_ready <= 1'b0;
      for (int k = 0; k < K; k++) w[k] <= '0;
    end else if (i_load) begin
      state     <= LOAD;
      wcnt      <= '0;
      o_w_ready <= 1'b1;
      o_x_ready <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (i_w_valid) begin
            w[wcnt] <= i_w;
            if (wcnt == W_LAST) begin
              state     <= RUN;
              wcnt      <= '0;
              o_w_ready <= 1'b0;
              o_x_ready <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sliding window, fill counter and the sideband captured with each sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < K; k++) win[k] <= '0;
      fill   <= '0;
      x_hit  <= 1'b0;
      x_psum <= '0;
      x_relu <= 1'b0;
    end else if (i_load) begin
      fill  <= '0;
      x_hit <= 1'b0;
    end else begin
      x_hit <= accept && (fill_next == FILL_FULL);
      if (accept) begin
        win[0] <= i_x;
        for (int k = 1; k < K; k++) win[k] <= win[k-1];
        fill   <= fill_next;
        x_psum <= i_psum;
        x_relu <= i_relu;
      end
    end
  end

  // Full-precision products of the current window against the weights.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < K; k++) s1_prod[k] <= '0;
      s1_valid <= 1'b0;
      s1_psum  <= '0;
      s1_relu  <= 1'b0;
    end else if (i_load) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= x_hit;
      if (x_hit) begin
        for (int k = 0; k < K; k++)
          s1_prod[k] <= $signed({{I_X{w[k][I_W-1]}}, w[k]}) *
                        $signed({{I_W{win[k][I_X-1]}}, win[k]});
        s1_psum <= x_psum;
        s1_relu <= x_relu;
      end
    end
  end

  // Sign-extended accumulate, clamp to the output range, then optional ReLU.
  always_comb begin
    acc = {{(ACC_W-I_PSUM){s1_psum[I_PSUM-1]}}, s1_psum};
    for (int k = 0; k < K; k++)
      acc = acc + {{(ACC_W-P_W){s1_prod[k][P_W-1]}}, s1_prod[k]};
    if (acc > SAT_MAX)
      sat_val = {1'b0, {(O_SAT-1){1'b1}}};
    else if (acc < SAT_MIN)
      sat_val = {1'b1, {(O_SAT-1){1'b0}}};
    else
      sat_val = acc[O_SAT-1:0];
    res_val = (s1_relu && sat_val[O_SAT-1]) ? '0 : sat_val;
  end

  // Output register: one-cycle strobe, value held between results.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_psum  <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= s1_valid;
      if (s1_valid) o_psum <= res_val;
    end
  end

endmodule

// File: tb/tb_conv_row_engine.sv
// tb/tb_conv_row_engine.sv - directed bench for conv_row_engine
module tb_conv_row_engine;

  localparam int K      = 5;
  localparam int I_X    = 8;
  localparam int I_W    = 8;
  localparam int I_PSUM = 16;
  localparam int O_SAT  = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     load;
  logic                     w_valid;
  logic signed [I_W-1:0]    w_in;
  logic                     w_ready;
  logic                     x_valid;
  logic signed [I_X-1:0]    x_in;
  logic signed [I_PSUM-1:0] psum_in;
  logic                     row_start;
  logic                     relu;
  logic                     x_ready;
  logic signed [O_SAT-1:0]  o_psum;
  logic                     o_valid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int res_val [$];
  int res_cyc [$];

  conv_row_engine #(.K(K), .I_X(I_X), .I_W(I_W), .I_PSUM(I_PSUM), .O_SAT(O_SAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_load(load), .i_w_valid(w_valid), .i_w(w_in),
    .o_w_ready(w_ready), .i_x_valid(x_valid), .i_x(x_in), .i_psum(psum_in),
    .i_row_start(row_start), .i_relu(relu), .o_x_ready(x_ready),
    .o_psum(o_psum), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      res_val.push_back(int'(o_psum));
      res_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_results();
    res_val.delete();
    res_cyc.delete();
  endtask

  task automatic load_weights(input int a, input int b, input int c, input int d, input int e);
    int wl [5];
    wl[0] = a; wl[1] = b; wl[2] = c; wl[3] = d; wl[4] = e;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w_valid = 1'b1;
      w_in    = I_W'(wl[k]);
      step();
    end
    w_valid = 1'b0;
  endtask

  task automatic send(input int x, input int ps, input logic rs, input logic rl, output int ac);
    x_valid   = 1'b1;
    x_in      = I_X'(x);
    psum_in   = I_PSUM'(ps);
    row_start = rs;
    relu      = rl;
    step();
    ac        = cyc;
    x_valid   = 1'b0;
    row_start = 1'b0;
    relu      = 1'b0;
    psum_in   = '0;
  endtask

  task automatic run_row(input int xbase, input int xstep, input int last_ps, input logic rl,
                         output int n, output int v);
    int ac;
    clear_results();
    for (int i = 0; i < 5; i++)
      send(xbase + i * xstep, (i == 4) ? last_ps : 0, (i == 0), (i == 4) ? rl : 1'b0, ac);
    repeat (4) step();
    n = res_val.size();
    v = (n > 0) ? res_val[n-1] : -999999;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_psum !== 16'sd0) begin
      errors++;
      $display("FAIL reset_out: valid=%0b psum=%0d expected 0/0", o_valid, o_psum);
    end
    checks++;
    if (w_ready !== 1'b0 || x_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: w_ready=%0b x_ready=%0b expected 0/0", w_ready, x_ready);
    end
  endtask

  task automatic test_ramp();
    int ac [7];
    int exp_v [3];
    exp_v[0] = 35; exp_v[1] = 50; exp_v[2] = 65;
    load_weights(1, 2, 3, 4, 5);
    checks++;
    if (x_ready !== 1'b1 || w_ready !== 1'b0) begin
      errors++;
      $display("FAIL ramp_ready: x_ready=%0b w_ready=%0b expected 1/0", x_ready, w_ready);
    end
    clear_results();
    for (int i = 0; i < 7; i++) send(i + 1, 0, 1'b0, 1'b0, ac[i]);
    repeat (4) step();
    checks++;
    if (res_val.size() != 3) begin
      errors++;
      $display("FAIL ramp_count: got %0d results expected 3", res_val.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (res_val[j] != exp_v[j]) begin
          errors++;
          $display("FAIL ramp_val[%0d]: got %0d expected %0d", j, res_val[j], exp_v[j]);
        end
        checks++;
        if (res_cyc[j] - ac[4+j] != 2) begin
          errors++;
          $display("FAIL ramp_latency[%0d]: got %0d expected 2", j, res_cyc[j] - ac[4+j]);
        end
      end
    end
    checks++;
    if (o_valid !== 1'b0 || o_psum !== 16'sd65) begin
      errors++;
      $display("FAIL ramp_hold: valid=%0b psum=%0d expected 0/65", o_valid, o_psum);
    end
  endtask

  task automatic test_psum_relu();
    int n;
    int v;
    run_row(1, 1, -35, 1'b0, n, v);
    checks++;
    if (n != 1 || v != 0) begin
      errors++;
      $display("FAIL psum_m35: got n=%0d v=%0d expected 1/0", n, v);
    end
    run_row(1, 1, -40, 1'b0, n, v);
    checks++;
    if (n != 1 || v != -5) begin
      errors++;
      $display("FAIL psum_m40: got n=%0d v=%0d expected 1/-5", n, v);
    end
    run_row(1, 1, -40, 1'b1, n, v);
    checks++;
    if (n != 1 || v != 0) begin
      errors++;
      $display("FAIL relu_m40: got n=%0d v=%0d expected 1/0", n, v);
    end
  endtask

  task automatic test_saturation();
    int n;
    int v;
    load_weights(127, 127, 127, 127, 127);
    run_row(127, 0, 32767, 1'b0, n, v);
    checks++;
    if (n != 1 || v != 32767) begin
      errors++;
      $display("FAIL sat_pos: got n=%0d v=%0d expected 1/32767", n, v);
    end
    load_weights(-128, -128, -128, -128, -128);
    run_row(127, 0, -32768, 1'b0, n, v);
    checks++;
    if (n != 1 || v != -32768) begin
      errors++;
      $display("FAIL sat_neg: got n=%0d v=%0d expected 1/-32768", n, v);
    end
    run_row(127, 0, -32768, 1'b1, n, v);
    checks++;
    if (n != 1 || v != 0) begin
      errors++;
      $display("FAIL sat_neg_relu: got n=%0d v=%0d expected 1/0", n, v);
    end
  endtask

  task automatic test_row_restart();
    int ac [12];
    int exp_v [4];
    exp_v[0] = 35; exp_v[1] = 50; exp_v[2] = 65; exp_v[3] = 140;
    load_weights(1, 2, 3, 4, 5);
    clear_results();
    for (int i = 0; i < 12; i++) send(i + 1, 0, (i == 7), 1'b0, ac[i]);
    repeat (4) step();
    checks++;
    if (res_val.size() != 4) begin
      errors++;
      $display("FAIL restart_count: got %0d results expected 4", res_val.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (res_val[j] != exp_v[j]) begin
          errors++;
          $display("FAIL restart_val[%0d]: got %0d expected %0d", j, res_val[j], exp_v[j]);
        end
      end
      checks++;
      if (res_cyc[3] - ac[11] != 2) begin
        errors++;
        $display("FAIL restart_latency: got %0d expected 2", res_cyc[3] - ac[11]);
      end
    end
  endtask

  task automatic test_gaps();
    int ac [7];
    int exp_v [3];
    int gap;
    exp_v[0] = 35; exp_v[1] = 50; exp_v[2] = 65;
    clear_results();
    for (int i = 0; i < 7; i++) begin
      send(i + 1, 0, (i == 0), 1'b0, ac[i]);
      gap = int'($urandom_range(0, 3));
      repeat (gap) step();
    end
    repeat (4) step();
    checks++;
    if (res_val.size() != 3) begin
      errors++;
      $display("FAIL gaps_count: got %0d results expected 3", res_val.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (res_val[j] != exp_v[j] || res_cyc[j] - ac[4+j] != 2) begin
          errors++;
          $display("FAIL gaps_res[%0d]: got %0d lat %0d expected %0d lat 2",
                   j, res_val[j], res_cyc[j] - ac[4+j], exp_v[j]);
        end
      end
    end
  endtask

  task automatic test_load_handshake();
    int wl [5];
    int k;
    int cycles;
    int ac;
    wl[0] = 2; wl[1] = -1; wl[2] = 3; wl[3] = 0; wl[4] = 1;
    clear_results();
    load = 1'b1;
    step();
    load = 1'b0;
    x_valid = 1'b1;
    x_in    = 8'sd9;
    k = 0;
    cycles = 0;
    while (k < 5 && cycles < 40) begin
      checks++;
      if (x_ready !== 1'b0 || w_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready: x_ready=%0b w_ready=%0b expected 0/1", x_ready, w_ready);
      end
      if (cycles % 2 == 1) begin
        w_valid = 1'b0;
        w_in    = I_W'(99);
      end else begin
        w_valid = 1'b1;
        w_in    = I_W'(wl[k]);
        k++;
      end
      step();
      cycles++;
    end
    w_valid = 1'b0;
    x_valid = 1'b0;
    checks++;
    if (x_ready !== 1'b1 || w_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_done: x_ready=%0b w_ready=%0b expected 1/0", x_ready, w_ready);
    end
    repeat (3) step();
    checks++;
    if (res_val.size() != 0) begin
      errors++;
      $display("FAIL load_x_ignored: got %0d results expected 0", res_val.size());
    end
    w_valid = 1'b1;
    w_in    = I_W'(50);
    for (int i = 0; i < 5; i++) send(i + 1, 0, 1'b0, 1'b0, ac);
    w_valid = 1'b0;
    repeat (4) step();
    checks++;
    if (res_val.size() != 1 || res_val[0] != 16) begin
      errors++;
      $display("FAIL load_weights_val: got n=%0d v=%0d expected 1/16",
               res_val.size(), (res_val.size() > 0) ? res_val[0] : -999999);
    end
  endtask

  task automatic test_load_inflight();
    int ac;
    clear_results();
    for (int i = 0; i < 6; i++) send(i + 1, 0, (i == 0), 1'b0, ac);
    load_weights(1, 2, 3, 4, 5);
    repeat (4) step();
    checks++;
    if (res_val.size() != 0) begin
      errors++;
      $display("FAIL inflight_dropped: got %0d results expected 0", res_val.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int ac;
    int n;
    int v;
    clear_results();
    for (int i = 0; i < 6; i++) send(i + 1, 0, (i == 0), 1'b0, ac);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_psum !== 16'sd0 || w_ready !== 1'b0 || x_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out: valid=%0b psum=%0d w_ready=%0b x_ready=%0b expected all 0",
               o_valid, o_psum, w_ready, x_ready);
    end
    x_valid = 1'b1;
    x_in    = 8'sd7;
    repeat (6) step();
    x_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (res_val.size() != 0 || x_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: got n=%0d x_ready=%0b expected 0/0", res_val.size(), x_ready);
    end
    load_weights(1, 2, 3, 4, 5);
    run_row(1, 1, 0, 1'b0, n, v);
    checks++;
    if (n != 1 || v != 35) begin
      errors++;
      $display("FAIL midrst_reload: got n=%0d v=%0d expected 1/35", n, v);
    end
  endtask

  initial begin
    rst       = 1'b1;
    load      = 1'b0;
    w_valid   = 1'b0;
    w_in      = '0;
    x_valid   = 1'b0;
    x_in      = '0;
    psum_in   = '0;
    row_start = 1'b0;
    relu      = 1'b0;
    test_reset();
    test_ramp();
    test_psum_relu();
    test_saturation();
    test_row_restart();
    test_gaps();
    test_load_handshake();
    test_load_inflight();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
